// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/
// memory/write-back and handshakes with unified memory and the multiplier.
module mips_multicycle_ctrl #(
  parameter int CNT_W        = 32,
  parameter int MULT_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             mult_done,
  output logic             mem_req,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUControl,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             mult_start,
  output logic             lo_to_reg,
  output logic             mult_err,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL   = 6'h00, FN_JR   = 6'h08, FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18, FN_ADD  = 6'h20, FN_OR   = 6'h25;

  localparam int MW = $clog2(MULT_TIMEOUT + 1);
  localparam logic [MW-1:0] MCNT_LAST = MW'(MULT_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMRD     = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWR     = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_JAL       = 4'd11,
    S_JR        = 4'd12,
    S_MULT_WAIT = 4'd13,
    S_MFLO_WB   = 4'd14
  } state_t;

  state_t           state_q, state_d;
  logic             regdst_rd_q, regdst_rd_d;
  logic [MW-1:0]    mcnt_q, mcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      regdst_rd_q <= 1'b0;
      mcnt_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      regdst_rd_q <= regdst_rd_d;
      mcnt_q      <= mcnt_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    regdst_rd_d = regdst_rd_q;
    mcnt_d      = '0;
    err_d       = err_q;
    retire      = 1'b0;
    mem_req     = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCSrc       = 2'd0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUControl  = 4'd2;
    RegWrite    = 1'b0;
    RegDst      = 2'd0;
    MemtoReg    = 2'd0;
    mult_start  = 1'b0;
    lo_to_reg   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'd1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH can take it from ALUOut.
        ALUSrcB = 2'd3;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
          OP_RTYPE: begin
            case (funct)
              FN_JR:   state_d = S_JR;
              FN_MFLO: state_d = S_MFLO_WB;
              default: state_d = S_EXEC_R;
            endcase
          end
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        case (funct)
          FN_OR:   ALUControl = 4'd6;
          FN_SLL:  ALUControl = 4'd8;
          FN_ADD:  ALUControl = 4'd2;
          default: ALUControl = 4'd2;
        endcase
        if (funct == FN_MULT) begin
          mult_start = 1'b1;
          state_d    = S_MULT_WAIT;
        end else begin
          RegDst      = 2'd1;
          regdst_rd_d = 1'b1;
          state_d     = S_ALU_WB;
        end
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        case (opcode)
          OP_SLTI: ALUControl = 4'd12;
          OP_ANDI: ALUControl = 4'd5;
          OP_ORI:  ALUControl = 4'd6;
          OP_LUI:  ALUControl = 4'd11;
          default: ALUControl = 4'd2;
        endcase
        regdst_rd_d = 1'b0;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = {1'b0, regdst_rd_q};
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = 4'd3;
        PCSrc      = 2'd1;
        PCWrite    = (opcode == OP_BEQ) ? zero : !zero;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'd2;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        // PC still holds PC+4 this cycle, so the link value is written before the jump lands.
        PCWrite  = 1'b1;
        PCSrc    = 2'd2;
        RegWrite = 1'b1;
        RegDst   = 2'd2;
        MemtoReg = 2'd2;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JR: begin
        PCWrite = 1'b1;
        PCSrc   = 2'd3;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_MULT_WAIT: begin
        mcnt_d = mcnt_q + 1'b1;
        if (mult_done) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (mcnt_q == MCNT_LAST) begin
          err_d   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MFLO_WB: begin
        RegWrite  = 1'b1;
        RegDst    = 2'd1;
        lo_to_reg = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    cnt_d = cnt_q + CNT_W'(retire);

    // Whatever state is registered, nothing may be written while reset is held.
    if (reset) begin
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      mult_start = 1'b0;
      lo_to_reg  = 1'b0;
    end
  end

  assign state_o     = state_q;
  assign mult_err    = err_q;
  assign instr_count = cnt_q;

endmodule
